// File: rtl/im_loader.sv
// ============================================================================
//  Module      : im_loader
//  Description : Boot-time instruction memory writer. Assembles little-endian
//                32-bit words from a byte stream (header N, N data words,
//                XOR checksum), writes them to the IM and releases the core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module im_loader #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic             im_we,
    output logic [31:0]      im_waddr,
    output logic [31:0]      im_wdata,
    output logic [CNT_W-1:0] words_loaded,
    output logic             cpu_run,
    output logic             load_err
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_HDR  = 3'd1;
    localparam logic [2:0] c_DATA = 3'd2;
    localparam logic [2:0] c_CSUM = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;
    localparam logic [2:0] c_ERR  = 3'd5;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [31:0]      c_DEPTH   = 32'(DEPTH);

    generate
        if ((2 ** CNT_W) <= DEPTH) begin : g_param_check
            $error("im_loader: CNT_W too narrow for DEPTH");
        end
    endgenerate

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [1:0]       r_idx;
    logic [23:0]      r_asm;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_wcnt;
    logic [31:0]      r_acc;
    logic             r_we;
    logic [31:0]      r_waddr;
    logic [31:0]      r_wdata;

    logic             w_ready;
    logic             w_xfer;
    logic             w_last;
    logic [31:0]      w_word;
    logic [CNT_W-1:0] w_wcnt_inc;

    assign w_xfer     = in_valid & w_ready;
    assign w_last     = w_xfer && (r_idx == 2'd3);
    // Three earlier bytes sit in r_asm, oldest in the low byte.
    assign w_word     = {in_byte, r_asm};
    assign w_wcnt_inc = r_wcnt + c_CNT_ONE;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: w_state_nxt = c_HDR;
            c_HDR: begin
                if (w_last) begin
                    if (w_word > c_DEPTH) begin
                        w_state_nxt = c_ERR;
                    end else if (w_word == 32'd0) begin
                        w_state_nxt = c_CSUM;
                    end else begin
                        w_state_nxt = c_DATA;
                    end
                end
            end
            c_DATA: begin
                if (w_last && (w_wcnt_inc == r_n)) begin
                    w_state_nxt = c_CSUM;
                end
            end
            c_CSUM: begin
                if (w_last) begin
                    w_state_nxt = ((r_acc ^ w_word) == 32'd0) ? c_DONE : c_ERR;
                end
            end
            c_DONE:  w_state_nxt = c_DONE;
            c_ERR:   w_state_nxt = c_ERR;
            default: w_state_nxt = c_ERR;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_ready  = 1'b0;
        cpu_run  = 1'b0;
        load_err = 1'b0;
        case (r_state)
            c_HDR, c_DATA, c_CSUM: w_ready  = 1'b1;
            c_DONE:                cpu_run  = 1'b1;
            c_ERR:                 load_err = 1'b1;
            default: begin
                w_ready  = 1'b0;
                cpu_run  = 1'b0;
                load_err = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: byte assembly, header capture, word writes, checksum
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 2'd0;
            r_asm   <= 24'd0;
            r_n     <= '0;
            r_wcnt  <= '0;
            r_acc   <= 32'd0;
            r_we    <= 1'b0;
            r_waddr <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            r_we <= 1'b0;
            if (w_xfer) begin
                r_idx <= r_idx + 2'd1;
                r_asm <= {in_byte, r_asm[23:8]};
            end
            if (w_last) begin
                case (r_state)
                    c_HDR: begin
                        // Only meaningful when N <= DEPTH, which fits in CNT_W.
                        r_n <= w_word[CNT_W-1:0];
                    end
                    c_DATA: begin
                        r_we    <= 1'b1;
                        r_waddr <= {{(32-CNT_W){1'b0}}, r_wcnt};
                        r_wdata <= w_word;
                        r_acc   <= r_acc ^ w_word;
                        r_wcnt  <= w_wcnt_inc;
                    end
                    default: begin
                        r_n <= r_n;
                    end
                endcase
            end
        end
    end

    assign in_ready     = w_ready;
    assign im_we        = r_we;
    assign im_waddr     = r_waddr;
    assign im_wdata     = r_wdata;
    assign words_loaded = r_wcnt;

endmodule

`default_nettype wire

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time writer for the instruction memory.
- Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives a synchronous write port into the instruction memory.
- Verifies an XOR checksum over the loaded words, then releases the core by asserting CPU_RUN.
- While loading, the core is held and the instruction memory is owned by this block.

Parameters:
- DEPTH, 32, number of 32-bit words in the instruction memory. Header counts above DEPTH are rejected.
- CNT_W, 6, width of the word counter. Must satisfy 2^CNT_W > DEPTH.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  a byte is present on IN_BYTE.
- IN_BYTE  input  8  stream byte.
- IN_READY  output  1  loader accepts a byte this cycle.
- IM_WE  output  1  instruction memory write enable, one-cycle pulse per word.
- IM_WADDR  output  32  word index to write. The memory is indexed directly by word, not by byte address.
- IM_WDATA  output  32  assembled instruction word.
- WORDS_LOADED  output  CNT_W  count of words written so far.
- CPU_RUN  output  1  load succeeded; core may fetch. Sticky until RST.
- LOAD_ERR  output  1  load failed. Sticky until RST.

Behaviour:
- Clock and reset: one clock domain, CLK. RST is asynchronous and active-high.
- Reset values: state=IDLE; IN_READY=0; IM_WE=0; IM_WADDR=0; IM_WDATA=0; WORDS_LOADED=0; CPU_RUN=0; LOAD_ERR=0. The byte assembler and the checksum accumulator also clear to 0.
- Byte transfer: a byte transfers on a rising CLK edge when IN_VALID=1 and IN_READY=1. At most one byte transfers per cycle.
- IN_READY is a decode of state: 1 in HDR, DATA and CSUM; 0 elsewhere.
- Byte order: each field is 4 bytes, little-endian. The first byte received goes to bits [7:0], the fourth to bits [31:24].
- A 2-bit byte index tracks position within the current field. It wraps 3->0 on the fourth byte.
- States:
  - IDLE: entered on reset. Moves to HDR on the next edge, unconditionally.
  - HDR: collect 4 bytes as N, the word count. On the 4th byte:
    - N > DEPTH -> ERR.
    - N == 0 -> CSUM.
    - otherwise -> DATA.
  - DATA: collect words. On the 4th byte of each word:
    - the next edge registers IM_WE=1, IM_WADDR=current word index, IM_WDATA=assembled word;
    - the word is XORed into the checksum accumulator;
    - WORDS_LOADED increments.
    - After word N-1 -> CSUM.
  - CSUM: collect 4 bytes as C. On the 4th byte:
    - C == accumulator -> DONE;
    - otherwise -> ERR.
  - DONE: CPU_RUN=1 from the edge that enters DONE. Terminal until RST.
  - ERR: LOAD_ERR=1 from the edge that enters ERR. Terminal until RST.
- Write timing:
  - IM_WE is high for exactly one cycle per word, one cycle after the accepting edge of the word's 4th byte.
  - IM_WADDR and IM_WDATA hold their last value when IM_WE=0.
  - Back-to-back words with continuous IN_VALID produce one write every 4 cycles.
- Word indices: writes use indices 0..N-1 in order. No address wrap is possible, because N <= DEPTH.
- Stalls: IN_VALID=0 mid-field stalls the loader with no timeout. Partial bytes and the byte index are held.
- CPU_RUN and LOAD_ERR are mutually exclusive. Neither is ever asserted while state is HDR, DATA or CSUM.
- Reset mid-load: all state clears immediately and asynchronously.
  - A pending IM_WE is dropped.
  - Words already written stay in memory, but CPU_RUN stays 0 until a complete, successful reload.
- Input in terminal states: with IN_READY=0, bytes presented in DONE or ERR are not consumed and have no effect.

Test Plan:
- Basic load: stream 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | 80 00 10 00 with IN_VALID held high.
  - IM_WE pulses twice: (addr 0, 0x00000013) and (addr 1, 0x00100093), 4 cycles apart.
  - WORDS_LOADED reaches 2.
  - CPU_RUN=1 after the last checksum byte; LOAD_ERR=0.
- Bad checksum: same stream but checksum 81 00 10 00.
  - Both writes occur.
  - LOAD_ERR=1, CPU_RUN=0, IN_READY=0 afterwards.
- Oversize header: header 21 00 00 00 (33 > DEPTH).
  - LOAD_ERR=1 right after the 4th header byte.
  - No IM_WE pulse ever.
- Zero-length load: header 00 00 00 00, checksum 00 00 00 00.
  - No writes.
  - CPU_RUN=1; WORDS_LOADED=0.
- Stalls: basic load with IN_VALID deasserted for 3 cycles between bytes 2 and 3 of word 1.
  - Identical write data and addresses to the basic load.
  - IM_WE for word 1 is delayed by exactly 3 cycles.
- Reset mid-load: assert RST asynchronously, between edges, after byte 2 of word 1.
  - All outputs go to their reset values immediately.
  - After release: one IDLE cycle with IN_READY=0, then IN_READY=1.
  - A full basic-load stream then completes with CPU_RUN=1.
